// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, master FSM encoding, timeout counter width.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned TMO_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI-Lite master: turns one command into one bus transaction
// and returns one response, with an optional per-transaction timeout.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   cmd_*                        command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                        response out (valid/ready, rdata, resp, timeout), busy
//   m_axil_*                     AXI-Lite master channels AW, W, B, AR, R
module axil_cmd_master
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              busy,

    output logic [ADDR_W-1:0] m_axil_awaddr,
    output logic              m_axil_awvalid,
    input  logic              m_axil_awready,
    output logic [DATA_W-1:0] m_axil_wdata,
    output logic [STRB_W-1:0] m_axil_wstrb,
    output logic              m_axil_wvalid,
    input  logic              m_axil_wready,
    input  logic [1:0]        m_axil_bresp,
    input  logic              m_axil_bvalid,
    output logic              m_axil_bready,
    output logic [ADDR_W-1:0] m_axil_araddr,
    output logic              m_axil_arvalid,
    input  logic              m_axil_arready,
    input  logic [DATA_W-1:0] m_axil_rdata,
    input  logic [1:0]        m_axil_rresp,
    input  logic              m_axil_rvalid,
    output logic              m_axil_rready
);

    state_t             state, state_nxt;
    logic [TMO_W-1:0]   cnt, cnt_nxt;
    logic               tmo_hit, rsp_done;

    logic               cmd_ready_nxt, busy_nxt;
    logic               rsp_valid_nxt, rsp_timeout_nxt;
    logic [DATA_W-1:0]  rsp_rdata_nxt;
    logic [1:0]         rsp_resp_nxt;
    logic [ADDR_W-1:0]  awaddr_nxt, araddr_nxt;
    logic [DATA_W-1:0]  wdata_nxt;
    logic [STRB_W-1:0]  wstrb_nxt;
    logic               awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;

    // State and all outputs are registered from their next-values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= RESP_OKAY;
            rsp_timeout    <= 1'b0;
            m_axil_awaddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            cmd_ready      <= cmd_ready_nxt;
            busy           <= busy_nxt;
            rsp_valid      <= rsp_valid_nxt;
            rsp_rdata      <= rsp_rdata_nxt;
            rsp_resp       <= rsp_resp_nxt;
            rsp_timeout    <= rsp_timeout_nxt;
            m_axil_awaddr  <= awaddr_nxt;
            m_axil_awvalid <= awvalid_nxt;
            m_axil_wdata   <= wdata_nxt;
            m_axil_wstrb   <= wstrb_nxt;
            m_axil_wvalid  <= wvalid_nxt;
            m_axil_bready  <= bready_nxt;
            m_axil_araddr  <= araddr_nxt;
            m_axil_arvalid <= arvalid_nxt;
            m_axil_rready  <= rready_nxt;
        end
    end

    // Next-state and next-output logic; every register holds by default.
    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_resp_nxt    = rsp_resp;
        rsp_timeout_nxt = rsp_timeout;
        awaddr_nxt      = m_axil_awaddr;
        awvalid_nxt     = m_axil_awvalid;
        wdata_nxt       = m_axil_wdata;
        wstrb_nxt       = m_axil_wstrb;
        wvalid_nxt      = m_axil_wvalid;
        bready_nxt      = m_axil_bready;
        araddr_nxt      = m_axil_araddr;
        arvalid_nxt     = m_axil_arvalid;
        rready_nxt      = m_axil_rready;
        tmo_hit         = 1'b0;
        rsp_done        = 1'b0;

        // Counter runs only while waiting on the bus; limit is hit on the edge it reaches TIMEOUT.
        if (state inside {ST_WR_REQ, ST_WR_RESP, ST_RD_REQ, ST_RD_RESP}) begin
            cnt_nxt = cnt + TMO_W'(1);
            tmo_hit = (TIMEOUT != 0) && (32'(cnt_nxt) >= TIMEOUT);
        end

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cnt_nxt = '0;
                    if (cmd_write) begin
                        awaddr_nxt  = cmd_addr;
                        wdata_nxt   = cmd_wdata;
                        wstrb_nxt   = cmd_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = ST_WR_REQ;
                    end else begin
                        araddr_nxt  = cmd_addr;
                        arvalid_nxt = 1'b1;
                        state_nxt   = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                // AW and W retire independently; advance once both are gone.
                if (m_axil_awready) awvalid_nxt = 1'b0;
                if (m_axil_wready)  wvalid_nxt  = 1'b0;
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_axil_bvalid) begin
                    rsp_done        = 1'b1;
                    bready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = '0;
                    rsp_resp_nxt    = m_axil_bresp;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (m_axil_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                if (m_axil_rvalid) begin
                    rsp_done        = 1'b1;
                    rready_nxt      = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    rsp_rdata_nxt   = m_axil_rdata;
                    rsp_resp_nxt    = m_axil_rresp;
                    rsp_timeout_nxt = 1'b0;
                    state_nxt       = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Timeout abort: a response landing on the same edge takes precedence.
        if (tmo_hit && !rsp_done) begin
            awvalid_nxt     = 1'b0;
            wvalid_nxt      = 1'b0;
            bready_nxt      = 1'b0;
            arvalid_nxt     = 1'b0;
            rready_nxt      = 1'b0;
            rsp_valid_nxt   = 1'b1;
            rsp_rdata_nxt   = '0;
            rsp_resp_nxt    = RESP_SLVERR;
            rsp_timeout_nxt = 1'b1;
            state_nxt       = ST_RSP;
        end

        cmd_ready_nxt = (state_nxt == ST_IDLE);
        busy_nxt      = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Self-checking bench for axil_cmd_master: directed vector table plus randomized
// transactions against a cycle-count model of the expected response.
module tb_axil_cmd_master;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int          TMO    = 8;
    localparam int          NEVER  = 99;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [STRB_W-1:0] cmd_wstrb = '0;
    logic              rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic [1:0]        bresp = 2'b00, rresp = 2'b00;
    logic              bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [DATA_W-1:0] rdata = '0;
    logic              rvalid = 1'b0, rready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axil_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready), .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
        .m_axil_bready(bready), .m_axil_araddr(araddr), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        int                aw_dly, w_dly, b_dly, ar_dly, r_dly;
        logic [1:0]        sresp;
        logic [DATA_W-1:0] srdata;
        int                hold;
        int                exp_lat;
        logic [1:0]        exp_resp;
        logic              exp_tmo;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected result from the slave's delays: completion cycle vs. timeout limit.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int   c_end;
        if (v.write) c_end = ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 1 + 1 + v.b_dly;
        else         c_end = 1 + v.ar_dly + 1 + v.r_dly;
        if (c_end <= TMO) begin
            r.exp_lat   = c_end + 1;
            r.exp_resp  = v.sresp;
            r.exp_tmo   = 1'b0;
            r.exp_rdata = v.write ? '0 : v.srdata;
        end else begin
            r.exp_lat   = TMO + 1;
            r.exp_resp  = 2'b10;
            r.exp_tmo   = 1'b1;
            r.exp_rdata = '0;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int                errs = 0, b_cnt = 0, lat = 0;
        int                aw_hs, w_hs, ar_hs, b_start, r_start;
        bit                seen = 0, b_taken = 0, r_taken = 0, got = 0;
        logic [DATA_W-1:0] s_rdata;
        logic [1:0]        s_resp;
        logic              s_tmo;
        aw_hs   = 1 + v.aw_dly;
        w_hs    = 1 + v.w_dly;
        ar_hs   = 1 + v.ar_dly;
        b_start = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + v.b_dly;
        r_start = ar_hs + 1 + v.r_dly;

        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = cmd_ready;
        end
        chk("cmd_ready_wait", 64'(got), 64'd1);
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
        @(posedge clk); #1;
        cmd_valid = 1'b0;

        for (int k = 1; k <= 40 && !seen; k++) begin
            awready = v.write && (k == aw_hs);
            wready  = v.write && (k == w_hs);
            bvalid  = v.write && (k >= b_start) && !b_taken;
            bresp   = v.sresp;
            arready = !v.write && (k == ar_hs);
            rvalid  = !v.write && (k >= r_start) && !r_taken;
            rresp   = v.sresp;
            rdata   = v.srdata;
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1; lat = k;
                s_rdata = rsp_rdata; s_resp = rsp_resp; s_tmo = rsp_timeout;
                if (awvalid || wvalid || arvalid || bready || rready || !busy || cmd_ready) errs++;
            end else begin
                if (v.write) begin
                    if (awvalid !== (k <= aw_hs)) errs++;
                    if (wvalid !== (k <= w_hs)) errs++;
                    if (awvalid && awaddr !== v.addr) errs++;
                    if (wvalid && (wdata !== v.wdata || wstrb !== v.wstrb)) errs++;
                    if (arvalid) errs++;
                end else begin
                    if (arvalid !== (k <= ar_hs)) errs++;
                    if (arvalid && araddr !== v.addr) errs++;
                    if (awvalid || wvalid) errs++;
                end
                if (bvalid && bready) begin b_cnt++; b_taken = 1; end
                if (rvalid && rready) r_taken = 1;
                @(posedge clk); #1;
            end
        end
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;

        chk("rsp_latency", 64'(lat), 64'(v.exp_lat));
        if (seen) begin
            chk("rsp_resp", 64'(s_resp), 64'(v.exp_resp));
            chk("rsp_timeout", 64'(s_tmo), 64'(v.exp_tmo));
            chk("rsp_rdata", 64'(s_rdata), 64'(v.exp_rdata));
            chk("b_accepted", 64'(b_cnt), 64'((v.write && !v.exp_tmo) ? 1 : 0));
            for (int h = 0; h < v.hold; h++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_rdata !== s_rdata || rsp_resp !== s_resp ||
                    rsp_timeout !== s_tmo || cmd_ready || !busy) errs++;
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            chk("after_rsp", 64'({rsp_valid, cmd_ready, busy}), 64'(3'b010));
        end
        chk("protocol_errs", 64'(errs), 64'd0);
    endtask

    vec_t vecs[10];
    vec_t rv;

    initial begin
        //          wr  addr     wdata         strb  aw w  b  ar     r  sresp  srdata        hold lat resp  tmo  rdata
        vecs[0] = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0,     0, 2'b00, 32'h0,        0, 3, 2'b00, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 12'h028, 32'h0,        4'h0, 0, 0, 0, 0,     0, 2'b00, 32'h00020001, 0, 3, 2'b00, 1'b0, 32'h00020001};
        vecs[2] = '{1'b1, 12'h0A4, 32'h13572468, 4'h5, 3, 0, 0, 0,     0, 2'b00, 32'h0,        1, 6, 2'b00, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 12'h300, 32'h0,        4'h0, 0, 0, 0, NEVER, 0, 2'b00, 32'h11111111, 0, 9, 2'b10, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 12'h100, 32'h0,        4'h0, 0, 0, 0, 0,     1, 2'b00, 32'h12345678, 0, 4, 2'b00, 1'b0, 32'h12345678};
        vecs[5] = '{1'b0, 12'h044, 32'h0,        4'h0, 0, 0, 0, 0,     0, 2'b11, 32'hA5A5A5A5, 5, 3, 2'b11, 1'b0, 32'hA5A5A5A5};
        vecs[6] = '{1'b1, 12'hFFC, 32'h0F0F0F0F, 4'h8, 0, 0, 2, 0,     0, 2'b01, 32'h0,        2, 5, 2'b01, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 12'h200, 32'h0,        4'h0, 0, 0, 0, 0,     6, 2'b00, 32'hCAFEF00D, 0, 9, 2'b00, 1'b0, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 12'h204, 32'h0,        4'h0, 0, 0, 0, 0,     7, 2'b00, 32'hCAFEF00D, 0, 9, 2'b10, 1'b1, 32'h0};
        vecs[9] = '{1'b1, 12'h208, 32'h99999999, 4'hC, 7, 0, 0, 0,     0, 2'b00, 32'h0,        0, 9, 2'b10, 1'b1, 32'h0};

        // Reset values
        #12;
        chk("reset_flags", 64'({cmd_ready, rsp_valid, rsp_timeout, busy, awvalid, wvalid, bready, arvalid, rready}),
            64'(9'b1_0000_0000));
        chk("reset_payload", 64'({awaddr, araddr, wstrb, rsp_resp}), 64'd0);
        chk("reset_data", {wdata, rsp_rdata}, 64'd0);
        @(negedge clk); rst_n = 1'b1;

        foreach (vecs[i]) run_txn(vecs[i]);

        // Mid-transaction reset while waiting for B
        begin
            logic seen_rsp = 1'b0;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h0C0;
            cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
            @(posedge clk); #1;
            cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
            @(posedge clk); #1;
            awready = 1'b0; wready = 1'b0;
            @(negedge clk);
            chk("in_wr_resp", 64'({bready, busy, cmd_ready}), 64'(3'b110));
            rst_n = 1'b0;
            #1;
            chk("midrst_flags", 64'({cmd_ready, rsp_valid, rsp_timeout, busy, awvalid, wvalid, bready, arvalid, rready}),
                64'(9'b1_0000_0000));
            chk("midrst_payload", 64'({awaddr, araddr, wstrb, rsp_resp}), 64'd0);
            chk("midrst_data", {wdata, rsp_rdata}, 64'd0);
            @(negedge clk); rst_n = 1'b1;
            bvalid = 1'b1;
            @(posedge clk); #1;
            chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (rsp_valid || bready) seen_rsp = 1'b1;
            end
            bvalid = 1'b0;
            chk("no_rsp_after_rst", 64'(seen_rsp), 64'd0);
        end

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            rv.write  = 1'($urandom);
            rv.addr   = ADDR_W'($urandom);
            rv.wdata  = $urandom;
            rv.wstrb  = STRB_W'($urandom);
            rv.aw_dly = $urandom_range(0, 4);
            rv.w_dly  = $urandom_range(0, 4);
            rv.b_dly  = $urandom_range(0, 4);
            rv.ar_dly = $urandom_range(0, 4);
            rv.r_dly  = $urandom_range(0, 5);
            rv.sresp  = 2'($urandom);
            rv.srdata = $urandom;
            rv.hold   = $urandom_range(0, 3);
            run_txn(model(rv));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; STRB_W = DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles waiting on the bus per transaction; 0 disables the timeout.
REQ-004 SHALL have ports `clk in 1` (clock) and `rst_n in 1` (reset, asynchronous, active-low).
REQ-005 SHALL have these command ports: `cmd_valid in 1`, `cmd_ready out 1`, `cmd_write in 1` (1=write), `cmd_addr in ADDR_W`, `cmd_wdata in DATA_W`, `cmd_wstrb in STRB_W`.
REQ-006 SHALL have these response ports: `rsp_valid out 1`, `rsp_ready in 1`, `rsp_rdata out DATA_W`, `rsp_resp out 2`, `rsp_timeout out 1`, `busy out 1`.
REQ-007 SHALL have AXI-Lite master ports m_axil_*: awaddr/awvalid out, awready in; wdata/wstrb/wvalid out, wready in; bresp/bvalid in, bready out; araddr/arvalid out, arready in; rdata/rresp/rvalid in, rready out.

Function
REQ-008 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-009 cmd_ready SHALL be 1 only in IDLE.
- On cmd_valid&&cmd_ready, addr/wdata/wstrb are latched.
- Next state is WR_REQ if cmd_write, else RD_REQ.
REQ-010 WR_REQ behaviour:
- awvalid and wvalid both assert on the cycle after acceptance.
- Each drops independently on its own handshake.
- Move to WR_RESP once both handshakes are done, in either order or in the same cycle.
REQ-011 WR_RESP SHALL drive bready=1.
- On bvalid, capture bresp, set rsp_rdata=0, go to RSP.
REQ-012 RD_REQ SHALL assert arvalid until arready, then go to RD_RESP.
REQ-013 RD_RESP SHALL drive rready=1.
- On rvalid, capture rdata and rresp, go to RSP.
REQ-014 RSP SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready, then return to IDLE.
- Back-to-back commands SHALL be possible: cmd_ready=1 the cycle after the rsp handshake.
REQ-015 AXI outputs SHALL be registered.
- Once asserted, valid and payload stay stable until the handshake completes (timeout excepted, REQ-017).
REQ-016 A 16-bit timeout counter SHALL clear on command acceptance and increment every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
REQ-017 When TIMEOUT!=0 and the counter reaches TIMEOUT, the block SHALL:
- deassert all AXI valid/ready outputs;
- go to RSP with rsp_resp=2'b10 (SLVERR), rsp_timeout=1, rsp_rdata=0.
This deliberate protocol abort is error recovery only.
REQ-018 rsp_timeout SHALL be 0 for every completed bus response.
REQ-019 A bus response arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, rsp_timeout=0.
REQ-020 Nonzero bresp/rresp values (SLVERR, DECERR) SHALL pass through unchanged.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 Minimum latency, with a slave that is always ready and responds one cycle after the handshake:
- write: cmd accept at cycle 0, aw/w handshake at 1, B handshake at 2, rsp_valid at 3;
- read: rsp_valid at 3 likewise.

Reset
REQ-023 On rst_n low, asynchronously:
- state=IDLE;
- all AXI valid/ready outputs 0, address/data/strobe outputs 0;
- rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, busy=0, timeout counter=0.
REQ-024 Reset during any state SHALL abandon the transaction with no response issued.
- cmd_ready SHALL be 1 on the first clock after release.

Structure
REQ-025 Shared package axil_pkg SHALL hold:
- RESP_OKAY/EXOKAY/SLVERR/DECERR constants (2'b00..2'b11);
- the FSM state encoding.
The register slave uses the same constants.
REQ-026 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-027 Write with a ready slave:
- stimulus: cmd write addr=12'h010, wdata=32'hDEADBEEF, wstrb=4'hF;
- required: AW/W carry these values, rsp_valid at cycle 3, rsp_resp=00, rsp_timeout=0.
REQ-028 Read:
- stimulus: cmd read addr=12'h028, slave returns rdata=32'h00020001;
- required: rsp_rdata=32'h00020001, rsp_resp=00.
REQ-029 Skewed write handshakes:
- stimulus: slave gives awready 3 cycles after wready;
- required: wvalid drops after its handshake, awvalid stays stable, exactly one B accepted.
REQ-030 Timeout:
- stimulus: TIMEOUT=8, slave never asserts arready;
- required: after 8 cycles arvalid=0, rsp_resp=10, rsp_timeout=1; then a following command succeeds.
REQ-031 Backpressure and error pass-through:
- stimulus: rsp_ready held 0 for 5 cycles, slave returns rresp=11;
- required: rsp_* stable and cmd_ready=0 throughout; rsp_resp=11 delivered.
REQ-032 Mid-transaction reset:
- stimulus: rst_n pulsed low in WR_RESP;
- required: all outputs at reset values, no rsp_valid; cmd_ready=1 after release.
